// File: rtl/rf_pkg.sv
// Shared constants, write-entry type and helpers for the register-file write arbiter.
package rf_pkg;

    localparam int unsigned NREQ     = 2;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned NUM_REGS = 15;
    localparam int unsigned IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rf_wr_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req_mask, searching upward from ptr with wrap-around.
    function automatic rr_pick_t rr_pick(input logic [NREQ-1:0] req_mask,
                                         input logic [IDX_W-1:0] ptr);
        rr_pick_t    pick;
        int unsigned cand;
        pick = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(ptr) + k) % NREQ;
            if (!pick.valid && req_mask[cand]) begin
                pick.valid = 1'b1;
                pick.idx   = IDX_W'(cand);
            end
        end
        return pick;
    endfunction

    function automatic logic [NUM_REGS-1:0] reg_decode(input logic [ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] m;
        m = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            m[r] = (addr == ADDR_W'(r));
        end
        return m;
    endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// Per-requester write FIFO; exposes per-slot valid/address so the top can build the pending mask.
module rf_wr_fifo
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  rf_wr_t                       i_wdata,
    input  logic                         i_pop,
    output logic                         o_full,
    output logic                         o_empty,
    output rf_wr_t                       o_head,
    output logic [DEPTH-1:0]             o_ent_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0] o_ent_addr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    rf_wr_t        r_mem [DEPTH];
    logic [PW-1:0] w_count;
    logic          w_do_push;
    logic          w_do_pop;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign w_count   = r_wp - r_rp;
    assign o_full    = (w_count == PW'(DEPTH));
    assign o_empty   = (r_wp == r_rp);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else if (i_flush) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_do_push) r_wp <= r_wp + 1'b1;
            if (w_do_pop)  r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) r_mem[r_wp[AW-1:0]] <= i_wdata;
    end

    always_comb begin
        logic [AW-1:0] w_off;
        o_ent_valid = '0;
        o_ent_addr  = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            w_off          = AW'(j) - r_rp[AW-1:0];
            o_ent_valid[j] = ({1'b0, w_off} < w_count);
            o_ent_addr[j]  = r_mem[j].addr;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between queued writeback requesters,
// with a pending-write scoreboard for RAW stalls in decode.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [NREQ-1:0]                 req_valid,
    output logic [NREQ-1:0]                 req_ready,
    input  logic [NREQ-1:0][ADDR_W-1:0]     req_rd,
    input  logic [NREQ-1:0][DATA_W-1:0]     req_wd,
    output logic                            we_RF,
    output logic [ADDR_W-1:0]               rd,
    output logic [DATA_W-1:0]               WD3,
    output logic [NUM_REGS-1:0]             pend_mask,
    output logic [NREQ-1:0]                 err_addr,
    output logic                            busy
);

    logic                             r_we;
    logic [ADDR_W-1:0]                r_rd;
    logic [DATA_W-1:0]                r_wd;
    logic [IDX_W-1:0]                 r_rr;
    logic [NREQ-1:0]                  r_err;

    logic [NREQ-1:0]                  w_full;
    logic [NREQ-1:0]                  w_empty;
    logic [NREQ-1:0]                  w_push;
    logic [NREQ-1:0]                  w_pop;
    logic [NREQ-1:0]                  w_bad;
    rf_wr_t                           w_wdata     [NREQ];
    rf_wr_t                           w_head      [NREQ];
    logic [FIFO_DEPTH-1:0]            w_ent_valid [NREQ];
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0] w_ent_addr [NREQ];
    rr_pick_t                         w_pick;
    logic                             w_grant;
    rf_wr_t                           w_gnt_head;
    logic [IDX_W-1:0]                 w_rr_next;

    for (genvar g = 0; g < NREQ; g++) begin : g_fifo
        rf_wr_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .i_clk       (clk),
            .i_rst_n     (rst),
            .i_flush     (flush),
            .i_push      (w_push[g]),
            .i_wdata     (w_wdata[g]),
            .i_pop       (w_pop[g]),
            .o_full      (w_full[g]),
            .o_empty     (w_empty[g]),
            .o_head      (w_head[g]),
            .o_ent_valid (w_ent_valid[g]),
            .o_ent_addr  (w_ent_addr[g])
        );
    end

    // Ready comes from FIFO state alone; invalid addresses are accepted but never enqueued.
    always_comb begin
        w_pick     = rr_pick(~w_empty, r_rr);
        w_grant    = w_pick.valid && !flush;
        w_gnt_head = w_head[w_pick.idx];
        w_rr_next  = (w_pick.idx == IDX_W'(NREQ - 1)) ? '0 : w_pick.idx + 1'b1;
        req_ready  = ~w_full;
        w_push     = '0;
        w_pop      = '0;
        w_bad      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_wdata[i] = '{addr: req_rd[i], data: req_wd[i]};
            w_pop[i]   = w_grant && (w_pick.idx == IDX_W'(i));
            if (req_valid[i] && !w_full[i]) begin
                if (32'(req_rd[i]) < NUM_REGS) w_push[i] = !flush;
                else                           w_bad[i]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we  <= 1'b0;
            r_rd  <= '0;
            r_wd  <= '0;
            r_rr  <= '0;
            r_err <= '0;
        end else begin
            r_err <= w_bad;
            r_we  <= w_grant;
            if (w_grant) begin
                r_rd <= w_gnt_head.addr;
                r_wd <= w_gnt_head.data;
                r_rr <= w_rr_next;
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
                if (w_ent_valid[i][j]) pend_mask = pend_mask | reg_decode(w_ent_addr[i][j]);
            end
        end
        if (r_we) pend_mask = pend_mask | reg_decode(r_rd);
    end

    assign we_RF    = r_we;
    assign rd       = r_rd;
    assign WD3      = r_wd;
    assign err_addr = r_err;
    assign busy     = (~&w_empty) | r_we;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed-vector bench for rf_write_arbiter with hand-computed expected port sequences.
module tb_rf_write_arbiter;
    import rf_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst = 1'b0;
    logic                        flush = 1'b0;
    logic [NREQ-1:0]             req_valid = '0;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ-1:0][ADDR_W-1:0] req_rd = '0;
    logic [NREQ-1:0][DATA_W-1:0] req_wd = '0;
    logic                        we_RF;
    logic [ADDR_W-1:0]           rd;
    logic [DATA_W-1:0]           WD3;
    logic [NUM_REGS-1:0]         pend_mask;
    logic [NREQ-1:0]             err_addr;
    logic                        busy;

    int checks   = 0;
    int failures = 0;

    logic [ADDR_W-1:0] q0_rd [$];
    logic [ADDR_W-1:0] q1_rd [$];
    logic [DATA_W-1:0] q0_wd [$];
    logic [DATA_W-1:0] q1_wd [$];
    logic [ADDR_W-1:0] obs_rd [$];
    logic [DATA_W-1:0] obs_wd [$];
    int                obs_cyc [$];
    logic              rdy0_hist [$];

    rf_write_arbiter #(
        .FIFO_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rd    (req_rd),
        .req_wd    (req_wd),
        .we_RF     (we_RF),
        .rd        (rd),
        .WD3       (WD3),
        .pend_mask (pend_mask),
        .err_addr  (err_addr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        req_rd    = '0;
        req_wd    = '0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        tick();
    endtask

    // Offers queued beats with valid/ready until queues drain and the port goes idle.
    task automatic stream(input int max_cyc);
        int              guard;
        logic [NREQ-1:0] hs;
        guard = 0;
        obs_rd.delete();
        obs_wd.delete();
        obs_cyc.delete();
        rdy0_hist.delete();
        while ((q0_rd.size() != 0 || q1_rd.size() != 0 || busy) && guard < max_cyc) begin
            req_valid = '0;
            if (q0_rd.size() != 0) begin
                req_valid[0] = 1'b1;
                req_rd[0]    = q0_rd[0];
                req_wd[0]    = q0_wd[0];
            end
            if (q1_rd.size() != 0) begin
                req_valid[1] = 1'b1;
                req_rd[1]    = q1_rd[0];
                req_wd[1]    = q1_wd[0];
            end
            hs = req_valid & req_ready;
            tick();
            guard++;
            if (hs[0]) begin void'(q0_rd.pop_front()); void'(q0_wd.pop_front()); end
            if (hs[1]) begin void'(q1_rd.pop_front()); void'(q1_wd.pop_front()); end
            rdy0_hist.push_back(req_ready[0]);
            if (we_RF) begin
                obs_rd.push_back(rd);
                obs_wd.push_back(WD3);
                obs_cyc.push_back(guard);
            end
        end
        req_valid = '0;
        chk("stream_done", 64'(guard < max_cyc), 64'd1);
    endtask

    initial begin
        int unsigned exp3 [6];
        int unsigned e;
        int          nw;

        // Reset state
        do_reset();
        chk("rst_we", 64'(we_RF), 64'd0);
        chk("rst_rd", 64'(rd), 64'd0);
        chk("rst_wd3", 64'(WD3), 64'd0);
        chk("rst_pend", 64'(pend_mask), 64'd0);
        chk("rst_err", 64'(err_addr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd3);

        // Single write: accept, then on the port one cycle later
        req_valid = 2'b01;
        req_rd[0] = 4'd3;
        req_wd[0] = 32'hDEADBEEF;
        tick();
        req_valid = '0;
        chk("t1_pend_q", 64'(pend_mask), 64'h8);
        chk("t1_we_q", 64'(we_RF), 64'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        tick();
        chk("t1_we", 64'(we_RF), 64'd1);
        chk("t1_rd", 64'(rd), 64'd3);
        chk("t1_wd3", 64'(WD3), 64'hDEADBEEF);
        chk("t1_pend_port", 64'(pend_mask), 64'h8);
        tick();
        chk("t1_we_off", 64'(we_RF), 64'd0);
        chk("t1_pend_clr", 64'(pend_mask), 64'd0);
        chk("t1_rd_hold", 64'(rd), 64'd3);
        chk("t1_wd3_hold", 64'(WD3), 64'hDEADBEEF);
        chk("t1_idle", 64'(busy), 64'd0);

        // Backpressure: rr pointer now favours req1, so req0 fills after 2 beats
        for (int k = 0; k < 3; k++) begin
            q0_rd.push_back(4'(9 + k));
            q0_wd.push_back(32'hA000_0000 | 32'(9 + k));
            q1_rd.push_back(4'(12 + k));
            q1_wd.push_back(32'hB000_0000 | 32'(12 + k));
        end
        stream(40);
        exp3 = '{12, 9, 13, 10, 14, 11};
        chk("t3_count", 64'(obs_rd.size()), 64'd6);
        for (int k = 0; k < obs_rd.size() && k < 6; k++) begin
            e = exp3[k];
            chk($sformatf("t3_rd%0d", k), 64'(obs_rd[k]), 64'(e));
            chk($sformatf("t3_wd%0d", k), 64'(obs_wd[k]),
                64'(((e >= 12) ? 32'hB000_0000 : 32'hA000_0000) | e));
        end
        chk("t3_rdy0_e1", 64'(rdy0_hist[0]), 64'd1);
        chk("t3_rdy0_e2", 64'(rdy0_hist[1]), 64'd0);

        // Invalid address on req1
        req_valid = 2'b10;
        req_rd[1] = 4'd15;
        req_wd[1] = 32'h1234_5678;
        chk("t4_ready", 64'(req_ready[1]), 64'd1);
        tick();
        req_valid = '0;
        chk("t4_err", 64'(err_addr), 64'd2);
        chk("t4_we", 64'(we_RF), 64'd0);
        chk("t4_pend", 64'(pend_mask), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);
        tick();
        chk("t4_err_off", 64'(err_addr), 64'd0);
        chk("t4_we2", 64'(we_RF), 64'd0);

        // Contention after reset: strict alternation starting at req0
        do_reset();
        for (int k = 0; k < 4; k++) begin
            q0_rd.push_back(4'(1 + k));
            q0_wd.push_back(32'hA000_0000 | 32'(1 + k));
            q1_rd.push_back(4'(5 + k));
            q1_wd.push_back(32'hB000_0000 | 32'(5 + k));
        end
        stream(40);
        chk("t2_count", 64'(obs_rd.size()), 64'd8);
        for (int k = 0; k < obs_rd.size() && k < 8; k++) begin
            e = (k % 2 == 0) ? 32'(k / 2 + 1) : 32'(k / 2 + 5);
            chk($sformatf("t2_rd%0d", k), 64'(obs_rd[k]), 64'(e));
            chk($sformatf("t2_wd%0d", k), 64'(obs_wd[k]),
                64'(((k % 2 == 0) ? 32'hA000_0000 : 32'hB000_0000) | e));
        end
        if (obs_cyc.size() == 8)
            chk("t2_back2back", 64'(obs_cyc[7] - obs_cyc[0]), 64'd7);
        else
            chk("t2_back2back", 64'(obs_cyc.size()), 64'd8);

        // Flush while the first grant is on the port
        req_valid = 2'b11;
        req_rd[0] = 4'd1; req_wd[0] = 32'h0000_0011;
        req_rd[1] = 4'd4; req_wd[1] = 32'h0000_0044;
        tick();
        req_rd[0] = 4'd2; req_wd[0] = 32'h0000_0022;
        req_rd[1] = 4'd5; req_wd[1] = 32'h0000_0055;
        tick();
        chk("t5_we", 64'(we_RF), 64'd1);
        chk("t5_rd", 64'(rd), 64'd1);
        chk("t5_wd3", 64'(WD3), 64'h11);
        chk("t5_pend", 64'(pend_mask), 64'h36);
        flush     = 1'b1;
        req_valid = 2'b01;
        req_rd[0] = 4'd6; req_wd[0] = 32'h0000_0066;
        chk("t5_ready_pre", 64'(req_ready), 64'd1);
        tick();
        flush     = 1'b0;
        req_valid = '0;
        chk("t5_we_off", 64'(we_RF), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_pend_clr", 64'(pend_mask), 64'd0);
        chk("t5_ready", 64'(req_ready), 64'd3);
        tick();
        chk("t5_no_more", 64'(we_RF), 64'd0);

        // Async reset between edges while a write is on the port
        req_valid = 2'b01;
        req_rd[0] = 4'd2; req_wd[0] = 32'h0000_0202;
        tick();
        req_rd[0] = 4'd3; req_wd[0] = 32'h0000_0303;
        tick();
        req_valid = '0;
        chk("t6_we_pre", 64'(we_RF), 64'd1);
        chk("t6_pend_pre", 64'(pend_mask), 64'hC);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_we_rst", 64'(we_RF), 64'd0);
        chk("t6_pend_rst", 64'(pend_mask), 64'd0);
        chk("t6_rd_rst", 64'(rd), 64'd0);
        chk("t6_busy_rst", 64'(busy), 64'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        nw = 0;
        repeat (5) begin
            tick();
            if (we_RF) nw++;
        end
        chk("t6_no_write", 64'(nw), 64'd0);
        chk("t6_idle", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
